// File: rtl/uat_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter: one pending requester's byte per frame window.
// Latency: a request sampled in IDLE is granted and strobed to the transmitter one cycle later.
// Backpressure: after a strobe, loads are blocked for FRAME_CYCLES cycles; requests are ignored meanwhile.
module uat_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_CYCLES = 12
) (
  input  logic                   clk_x,
  input  logic                   rst_p,
  input  logic                   sched_en,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [2:0]             gnt_id,
  output logic                   tx_din_rdy,
  output logic [7:0]             tx_din_byte,
  output logic                   busy
);

  localparam int            CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_IDX = 3'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           gnt_id_q, gnt_id_d;
  logic                 rdy_q, rdy_d;
  logic [7:0]           byte_q, byte_d;

  // Requests and data padded to the maximum of 8 requesters so a 3-bit index always fits.
  logic [7:0]           req_ext;
  logic [63:0]          data_ext;
  logic [2:0]           cand;
  logic                 found_c;
  logic [2:0]           win_c;
  logic [7:0]           win_byte;

  // Rotating-priority search starting just after the last winner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    cand                   = ptr_q;
    found_c                = 1'b0;
    win_c                  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? 3'd0 : cand + 3'd1;
      if (!found_c && req_ext[cand]) begin
        found_c = 1'b1;
        win_c   = cand;
      end
    end
  end

  // Select the winning requester's byte.
  always_comb begin
    data_ext                   = '0;
    data_ext[8*NUM_REQ-1:0]    = req_data;
    win_byte                   = data_ext[{win_c, 3'b000} +: 8];
  end

  // Next-state and registered-output logic; strobes default low so they last one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    rdy_d    = 1'b0;
    byte_d   = byte_q;
    case (state_q)
      S_IDLE: begin
        if (sched_en && found_c) begin
          state_d  = S_WAIT;
          cnt_d    = CNT_LOAD;
          ptr_d    = win_c;
          gnt_id_d = win_c;
          rdy_d    = 1'b1;
          byte_d   = win_byte;
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (win_c == 3'(i));
          end
        end
      end
      S_WAIT: begin
        // The transmitter has no busy flag, so the window is purely timed.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset outranks a pending grant.
  always_ff @(posedge clk_x) begin
    if (rst_p) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= LAST_IDX;
      gnt_q    <= '0;
      gnt_id_q <= 3'd0;
      rdy_q    <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rdy_q    <= rdy_d;
      byte_q   <= byte_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign tx_din_rdy  = rdy_q;
  assign tx_din_byte = byte_q;
  assign busy        = (state_q == S_WAIT);

endmodule

// File: tb/tb_uat_tx_sched.sv
// Directed bench for uat_tx_sched: reset, single grant, rotation, sched_en gating, mid-window reset.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded by a cycle budget.
module tb_uat_tx_sched;

  logic        clk_x = 1'b0;
  logic        rst_p;
  logic        sched_en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [2:0]  gnt_id;
  logic        tx_din_rdy;
  logic [7:0]  tx_din_byte;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uat_tx_sched #(.NUM_REQ(4), .FRAME_CYCLES(12)) dut (
    .clk_x       (clk_x),
    .rst_p       (rst_p),
    .sched_en    (sched_en),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .tx_din_rdy  (tx_din_rdy),
    .tx_din_byte (tx_din_byte),
    .busy        (busy)
  );

  always #5 clk_x = ~clk_x;

  task automatic tick;
    @(posedge clk_x);
    #1;
  endtask

  task automatic do_reset;
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
  endtask

  // Ticks until a load strobe appears or the budget runs out; returns cycles taken.
  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!tx_din_rdy && cyc < 40);
  endtask

  task automatic test_reset;
    sched_en = 1'b1;
    req      = 4'b0000;
    req_data = 32'h43322110;
    rst_p    = 1'b1;
    tick();
    tick();
    rst_p = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id got %0d exp 0", gnt_id); end
    checks++; if (tx_din_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", tx_din_rdy); end
    checks++; if (tx_din_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h exp 00", tx_din_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    tick();
    checks++; if (tx_din_rdy !== 1'b0) begin errors++; $display("FAIL reset_idle_rdy got %b exp 0", tx_din_rdy); end
  endtask

  task automatic test_single;
    int bcnt;
    req_data = 32'h00A50000;
    req      = 4'b0100;
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    checks++; if (gnt_id !== 3'd2) begin errors++; $display("FAIL single_gnt_id got %0d exp 2", gnt_id); end
    checks++; if (tx_din_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy got %b exp 1", tx_din_rdy); end
    checks++; if (tx_din_byte !== 8'hA5) begin errors++; $display("FAIL single_byte got %h exp a5", tx_din_byte); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    bcnt = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++; if (tx_din_rdy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL single_strobe_width cycle %0d rdy %b gnt %b exp 0/0000", k, tx_din_rdy, gnt); end
      if (busy) bcnt++;
      else break;
    end
    checks++; if (bcnt !== 12) begin errors++; $display("FAIL single_busy_len got %0d exp 12", bcnt); end
    checks++; if (tx_din_byte !== 8'hA5) begin errors++; $display("FAIL single_byte_hold got %h exp a5", tx_din_byte); end
    checks++; if (gnt_id !== 3'd2) begin errors++; $display("FAIL single_id_hold got %0d exp 2", gnt_id); end
  endtask

  task automatic test_round_robin;
    int          cyc;
    logic [2:0]  exp_id [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [7:0]  exp_b  [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    logic [3:0]  exp_g;
    req_data = 32'h43322110;
    req      = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_grant(cyc);
      exp_g = 4'b0001 << exp_id[i];
      checks++; if (cyc !== ((i == 0) ? 1 : 13)) begin errors++; $display("FAIL rr_spacing grant %0d got %0d cycles exp %0d", i, cyc, (i == 0) ? 1 : 13); end
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt grant %0d got %b exp %b", i, gnt, exp_g); end
      checks++; if (gnt_id !== exp_id[i]) begin errors++; $display("FAIL rr_gnt_id grant %0d got %0d exp %0d", i, gnt_id, exp_id[i]); end
      checks++; if (tx_din_byte !== exp_b[i]) begin errors++; $display("FAIL rr_byte grant %0d got %h exp %h", i, tx_din_byte, exp_b[i]); end
    end
    req = 4'b0000;
  endtask

  task automatic test_alternate;
    int          cyc;
    logic [2:0]  exp_id [6] = '{3'd0, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [7:0]  exp_b  [6] = '{8'h10, 8'h32, 8'h10, 8'h21, 8'h32, 8'h10};
    req_data = 32'h43322110;
    req      = 4'b0101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wait_grant(cyc);
      checks++; if (cyc !== ((i == 0) ? 1 : 13)) begin errors++; $display("FAIL alt_spacing grant %0d got %0d cycles exp %0d", i, cyc, (i == 0) ? 1 : 13); end
      checks++; if (gnt_id !== exp_id[i]) begin errors++; $display("FAIL alt_gnt_id grant %0d got %0d exp %0d", i, gnt_id, exp_id[i]); end
      checks++; if (tx_din_byte !== exp_b[i]) begin errors++; $display("FAIL alt_byte grant %0d got %h exp %h", i, tx_din_byte, exp_b[i]); end
      if (i == 2) req = 4'b0111;
      if (i == 3) req = 4'b0101;
    end
    req = 4'b0000;
  endtask

  task automatic test_sched_en;
    int bcnt;
    sched_en = 1'b0;
    req_data = 32'h43322110;
    req      = 4'b0001;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (gnt !== 4'b0000 || tx_din_rdy !== 1'b0) begin errors++; $display("FAIL en_off_grant cycle %0d gnt %b rdy %b exp 0000/0", k, gnt, tx_din_rdy); end
    end
    sched_en = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL en_rise_gnt got %b exp 0001", gnt); end
    checks++; if (tx_din_rdy !== 1'b1) begin errors++; $display("FAIL en_rise_rdy got %b exp 1", tx_din_rdy); end
    sched_en = 1'b0;
    bcnt = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (busy) bcnt++;
      else break;
    end
    checks++; if (bcnt !== 12) begin errors++; $display("FAIL en_drop_window got %0d exp 12", bcnt); end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (tx_din_rdy !== 1'b0) begin errors++; $display("FAIL en_drop_regrant cycle %0d rdy %b exp 0", k, tx_din_rdy); end
    end
    req      = 4'b0000;
    sched_en = 1'b1;
  endtask

  task automatic test_reset_mid_window;
    req_data = 32'h43322110;
    req      = 4'b0010;
    do_reset();
    tick();
    req = 4'b0000;
    checks++; if (gnt_id !== 3'd1 || tx_din_byte !== 8'h21) begin errors++; $display("FAIL mid_first_grant id %0d byte %h exp 1/21", gnt_id, tx_din_byte); end
    repeat (4) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    req   = 4'b1000;
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
    checks++; if (gnt_id !== 3'd0) begin errors++; $display("FAIL mid_rst_gnt_id got %0d exp 0", gnt_id); end
    checks++; if (tx_din_byte !== 8'h00) begin errors++; $display("FAIL mid_rst_byte got %h exp 00", tx_din_byte); end
    checks++; if (gnt !== 4'b0000 || tx_din_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_no_grant gnt %b rdy %b exp 0000/0", gnt, tx_din_rdy); end
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_post_gnt got %b exp 1000", gnt); end
    checks++; if (gnt_id !== 3'd3) begin errors++; $display("FAIL mid_post_gnt_id got %0d exp 3", gnt_id); end
    checks++; if (tx_din_byte !== 8'h43 || tx_din_rdy !== 1'b1) begin errors++; $display("FAIL mid_post_load byte %h rdy %b exp 43/1", tx_din_byte, tx_din_rdy); end
    for (int k = 0; k < 15 && busy; k++) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_window_end busy %b exp 0", busy); end
  endtask

  task automatic test_pulse_in_wait;
    req_data = 32'h43322110;
    req      = 4'b0001;
    do_reset();
    tick();
    req = 4'b0000;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL pulse_first_gnt got %b exp 0001", gnt); end
    for (int k = 0; k < 31; k++) begin
      if (k == 3) req = 4'b0010;
      if (k == 6) req = 4'b0000;
      tick();
      checks++; if (gnt !== 4'b0000 || tx_din_rdy !== 1'b0) begin errors++; $display("FAIL pulse_no_grant cycle %0d gnt %b rdy %b exp 0000/0", k, gnt, tx_din_rdy); end
    end
  endtask

  initial begin
    rst_p    = 1'b1;
    sched_en = 1'b1;
    req      = 4'b0000;
    req_data = 32'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_alternate();
    test_sched_en();
    test_reset_mid_window();
    test_pulse_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

endmodule
